scheduler_admission_ctrl: RTL and testbench

Per-packet admission controller at the ingress of the PIFO scheduler, between the pipeline's AXI-Stream output and the five per-port output queues. Decodes the SUME destination bitmap on the first beat of each packet, checks each target queue's buffer-almost-full and PIFO-full flags, and latches a per-queue accept mask for the whole packet. Drives the buffer write enables and the one-per-packet PIFO insert strobes, and reports per-queue stored/dropped packet and byte statistics.

---
 rtl/scheduler_admission_ctrl.sv | 118 +++++++++++
 tb/tb_scheduler_admission_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/scheduler_admission_ctrl.sv
// Per-packet admission control at the PIFO scheduler ingress.
// Latches a per-queue accept mask on the first beat and gates writes for the packet.
module scheduler_admission_ctrl #(
  parameter int DATA_WIDTH           = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 160,
  parameter int NUM_QUEUES           = 5,
  parameter int C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  output logic                            s_axis_tready,
  input  logic [NUM_QUEUES-1:0]           s_axis_buffer_almost_full,
  input  logic [NUM_QUEUES-1:0]           s_axis_pifo_full,
  output logic [NUM_QUEUES-1:0]           m_axis_ctl_buffer_wr_en,
  output logic [NUM_QUEUES-1:0]           m_axis_ctl_pifo_in_en,
  output logic [NUM_QUEUES-1:0]           pkt_stored,
  output logic [NUM_QUEUES-1:0]           pkt_dropped,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bytes_stored,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bytes_dropped
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = C_S_AXI_DATA_WIDTH - 16;

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t                state_q;
  logic [NUM_QUEUES-1:0] mask_q;
  logic [NUM_QUEUES-1:0] drop_q;
  logic [15:0]           acc_q;

  logic                  beat;
  logic                  first;
  logic [7:0]            bmap;
  logic [NUM_QUEUES-1:0] dst;
  logic [NUM_QUEUES-1:0] acc_now;
  logic [NUM_QUEUES-1:0] mask_cur;
  logic [NUM_QUEUES-1:0] drop_cur;
  logic [15:0]           beat_bytes;
  logic [16:0]           sum;
  logic [15:0]           total;

  assign beat  = s_axis_tvalid & s_axis_tready;
  assign first = (state_q == IDLE);
  assign bmap  = s_axis_tuser[31:24];

  // Odd bitmap bits are the DMA/CPU ports, all folded onto queue 4.
  always_comb begin
    dst    = '0;
    dst[0] = bmap[0];
    dst[1] = bmap[2];
    dst[2] = bmap[4];
    dst[3] = bmap[6];
    dst[4] = bmap[1] | bmap[3] | bmap[5] | bmap[7];
  end

  assign acc_now  = dst & ~s_axis_buffer_almost_full
                        & ~s_axis_pifo_full;
  assign mask_cur = first ? acc_now : mask_q;
  assign drop_cur = first ? (dst & ~acc_now) : drop_q;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KW; i++)
      beat_bytes = beat_bytes + 16'(s_axis_tkeep[i]);
  end

  assign sum   = {1'b0, (first ? 16'd0 : acc_q)}
               + {1'b0, beat_bytes};
  assign total = sum[16] ? 16'hFFFF : sum[15:0];

  assign m_axis_ctl_buffer_wr_en = beat ? mask_cur : '0;
  assign m_axis_ctl_pifo_in_en   = (beat && first) ? acc_now : '0;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      drop_q        <= '0;
      acc_q         <= '0;
      s_axis_tready <= 1'b0;
      pkt_stored    <= '0;
      pkt_dropped   <= '0;
      bytes_stored  <= '0;
      bytes_dropped <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      pkt_stored    <= '0;
      pkt_dropped   <= '0;
      if (beat) begin
        acc_q <= total;
        if (s_axis_tlast) begin
          state_q       <= IDLE;
          pkt_stored    <= mask_cur;
          pkt_dropped   <= drop_cur;
          bytes_stored  <= (mask_cur != '0) ?
                           {{PW{1'b0}}, total} : '0;
          bytes_dropped <= (drop_cur != '0) ?
                           {{PW{1'b0}}, total} : '0;
        end else begin
          state_q <= IN_PKT;
          if (first) begin
            mask_q <= acc_now;
            drop_q <= dst & ~acc_now;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scheduler_admission_ctrl.sv
// Directed bench for scheduler_admission_ctrl.
// Hand-computed enables and statistics per beat.
module tb_scheduler_admission_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tvalid;
  logic         tlast;
  logic [31:0]  tkeep;
  logic [159:0] tuser;
  logic         tready;
  logic [4:0]   af;
  logic [4:0]   pf;
  logic [4:0]   wr_en;
  logic [4:0]   pifo_en;
  logic [4:0]   st;
  logic [4:0]   dr;
  logic [31:0]  b_st;
  logic [31:0]  b_dr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scheduler_admission_ctrl dut (
    .axis_aclk                 (clk),
    .axis_resetn               (rst_n),
    .s_axis_tvalid             (tvalid),
    .s_axis_tlast              (tlast),
    .s_axis_tkeep              (tkeep),
    .s_axis_tuser              (tuser),
    .s_axis_tready             (tready),
    .s_axis_buffer_almost_full (af),
    .s_axis_pifo_full          (pf),
    .m_axis_ctl_buffer_wr_en   (wr_en),
    .m_axis_ctl_pifo_in_en     (pifo_en),
    .pkt_stored                (st),
    .pkt_dropped               (dr),
    .bytes_stored              (b_st),
    .bytes_dropped             (b_dr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat, check the zero-latency enables mid-cycle, then clock it.
  task automatic beat(input logic v, input logic l,
                      input logic [31:0] k, input logic [7:0] d,
                      input logic [4:0] a, input logic [4:0] p,
                      input logic [4:0] e_wr, input logic [4:0] e_pi,
                      input string tag);
    tvalid       = v;
    tlast        = l;
    tkeep        = k;
    tuser        = '0;
    tuser[31:24] = d;
    af           = a;
    pf           = p;
    #4;
    chk({tag, "_wr"}, 32'(wr_en), 32'(e_wr));
    chk({tag, "_pifo"}, 32'(pifo_en), 32'(e_pi));
    step();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic stats(input logic [4:0] e_st, input logic [4:0] e_dr,
                       input logic [31:0] e_bs, input logic [31:0] e_bd,
                       input string tag);
    chk({tag, "_stored"}, 32'(st), 32'(e_st));
    chk({tag, "_dropped"}, 32'(dr), 32'(e_dr));
    chk({tag, "_bstored"}, b_st, e_bs);
    chk({tag, "_bdropped"}, b_dr, e_bd);
  endtask

  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

  initial begin
    rst_n  = 1'b0;
    tvalid = 1'b1;
    tlast  = 1'b0;
    tkeep  = FULL;
    tuser  = '0;
    tuser[31:24] = 8'h01;
    af = '0;
    pf = '0;
    #13;
    chk("rst_tready", 32'(tready), 0);
    chk("rst_wr", 32'(wr_en), 0);
    chk("rst_pifo", 32'(pifo_en), 0);
    stats(5'b0, 5'b0, 0, 0, "rst");
    tvalid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("tready_up", 32'(tready), 1);

    // 3-beat unicast with an idle gap: 32+32+16 bytes
    beat(1, 0, FULL, 8'h01, 0, 0, 5'b00001, 5'b00001, "t1b1");
    beat(0, 0, FULL, 8'h01, 0, 0, 5'b00000, 5'b00000, "t1gap");
    beat(1, 0, FULL, 8'h00, 5'h1F, 5'h1F, 5'b00001, 5'b00000, "t1b2");
    beat(1, 1, 32'h0000FFFF, 8'h00, 0, 0, 5'b00001, 5'b00000, "t1b3");
    stats(5'b00001, 5'b00000, 80, 0, "t1");
    step();
    stats(5'b00000, 5'b00000, 80, 0, "t1hold");

    // multicast q0-q3, q2 almost full: 32+8 bytes
    beat(1, 0, FULL, 8'h55, 5'b00100, 0, 5'b01011, 5'b01011, "t2b1");
    beat(1, 1, 32'h000000FF, 8'h55, 0, 0, 5'b01011, 5'b00000, "t2b2");
    stats(5'b01011, 5'b00100, 40, 40, "t2");

    // q4 with PIFO full only on first beat: whole packet dropped
    beat(1, 0, FULL, 8'h02, 0, 5'b10000, 5'b00000, 5'b00000, "t3b1");
    beat(1, 1, FULL, 8'h02, 0, 0, 5'b00000, 5'b00000, "t3b2");
    stats(5'b00000, 5'b10000, 0, 64, "t3");

    // single-beat packet back-to-back with a 2-beat packet
    beat(1, 1, 32'h0000000F, 8'h04, 0, 0, 5'b00010, 5'b00010, "t4a");
    stats(5'b00010, 5'b00000, 4, 0, "t4a");
    beat(1, 0, FULL, 8'h10, 0, 0, 5'b00100, 5'b00100, "t4b1");
    beat(1, 1, 32'h00000003, 8'h10, 0, 0, 5'b00100, 5'b00000, "t4b2");
    stats(5'b00100, 5'b00000, 34, 0, "t4b");

    // reset mid-packet; following beats form a new packet
    beat(1, 0, FULL, 8'h01, 0, 0, 5'b00001, 5'b00001, "t5b1");
    tvalid = 1'b1;
    tkeep  = FULL;
    #2;
    rst_n = 1'b0;
    #2;
    chk("t5rst_tready", 32'(tready), 0);
    chk("t5rst_wr", 32'(wr_en), 0);
    chk("t5rst_pifo", 32'(pifo_en), 0);
    stats(5'b0, 5'b0, 0, 0, "t5rst");
    tvalid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    beat(1, 0, FULL, 8'h04, 0, 0, 5'b00010, 5'b00010, "t5b3");
    beat(1, 1, FULL, 8'h01, 0, 0, 5'b00010, 5'b00000, "t5b4");
    stats(5'b00010, 5'b00000, 64, 0, "t5");

    // empty bitmap: no enables, no pulses, byte outputs cleared
    beat(1, 0, FULL, 8'h00, 0, 0, 5'b00000, 5'b00000, "t6b1");
    chk("t6_tready", 32'(tready), 1);
    beat(1, 1, FULL, 8'h00, 0, 0, 5'b00000, 5'b00000, "t6b2");
    stats(5'b00000, 5'b00000, 0, 0, "t6");
    chk("t6_tready2", 32'(tready), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
